ym2413_reg_write: RTL

- CPU-side register writer for the YM2413/VRC7 core.
- Decodes the two-port host interface into the flat register set consumed by ym2413_param_gen: address latch on A0=0, data write on A0=1.
  - Data writes update the user instrument, rhythm and per-channel fnum/block/sustain/key/instrument/volume registers.
- Generates the chip's write-busy status and per-channel key-on edge events for the envelope logic.

---
 rtl/ym2413_reg_pkg.sv | 21 ++
 rtl/ym2413_busy_timer.sv | 26 ++
 rtl/ym2413_reg_write.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ym2413_reg_pkg.sv
// Shared constants and types for the YM2413/VRC7 host register writer.
package ym2413_reg_pkg;
  localparam logic [7:0] ADR_UT_BASE  = 8'h00;
  localparam logic [7:0] ADR_RHY      = 8'h0E;
  localparam logic [7:0] ADR_FNUM_LO  = 8'h10;
  localparam logic [7:0] ADR_CTRL     = 8'h20;
  localparam logic [7:0] ADR_INST_VOL = 8'h30;

  localparam int NUM_CH        = 9;
  localparam int NUM_UT        = 8;
  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;
  localparam int WAIT_W        = 7;

  typedef logic [3:0] ch_idx_t;

  // True when adr selects channel ch inside the 16-entry bank starting at base.
  function automatic logic ch_hit(input logic [7:0] adr, input logic [7:0] base, input ch_idx_t ch);
    return (adr[7:4] == base[7:4]) && (adr[3:0] == ch);
  endfunction
endpackage

// File: rtl/ym2413_busy_timer.sv
// Write-wait down-counter: loads on strobe, counts to zero and holds, busy while non-zero.
module ym2413_busy_timer
  import ym2413_reg_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign busy = (count_reg != '0);
endmodule

// File: rtl/ym2413_reg_write.sv
// YM2413/VRC7 host register writer: address/data port decode, flat register set, busy and key-on events.
// Optional macro YM2413_WR_BUSY_DROP_EN: writes arriving while busy are discarded.
module ym2413_reg_write
  import ym2413_reg_pkg::*;
#(
  parameter int ADDR_WAIT = DEF_ADDR_WAIT,
  parameter int DATA_WAIT = DEF_DATA_WAIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_we,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d,
  output logic       busy,
  output logic [8:0] key_evt,
  output logic       r_ut_op0_am, r_ut_op0_vib, r_ut_op0_egtyp, r_ut_op0_ksr,
  output logic [3:0] r_ut_op0_mult,
  output logic [1:0] r_ut_op0_ksl,
  output logic [5:0] r_ut_op0_tl,
  output logic       r_ut_op0_wf,
  output logic [2:0] r_ut_op0_fb,
  output logic [3:0] r_ut_op0_ar, r_ut_op0_dr, r_ut_op0_sl, r_ut_op0_rr,
  output logic       r_ut_op1_am, r_ut_op1_vib, r_ut_op1_egtyp, r_ut_op1_ksr,
  output logic [3:0] r_ut_op1_mult,
  output logic [1:0] r_ut_op1_ksl,
  output logic       r_ut_op1_wf,
  output logic [3:0] r_ut_op1_ar, r_ut_op1_dr, r_ut_op1_sl, r_ut_op1_rr,
  output logic [8:0] r_ch0_fnum, r_ch1_fnum, r_ch2_fnum, r_ch3_fnum, r_ch4_fnum,
  output logic [8:0] r_ch5_fnum, r_ch6_fnum, r_ch7_fnum, r_ch8_fnum,
  output logic [2:0] r_ch0_block, r_ch1_block, r_ch2_block, r_ch3_block, r_ch4_block,
  output logic [2:0] r_ch5_block, r_ch6_block, r_ch7_block, r_ch8_block,
  output logic       r_ch0_sust_on, r_ch1_sust_on, r_ch2_sust_on, r_ch3_sust_on, r_ch4_sust_on,
  output logic       r_ch5_sust_on, r_ch6_sust_on, r_ch7_sust_on, r_ch8_sust_on,
  output logic       r_ch0_key_on, r_ch1_key_on, r_ch2_key_on, r_ch3_key_on, r_ch4_key_on,
  output logic       r_ch5_key_on, r_ch6_key_on, r_ch7_key_on, r_ch8_key_on,
  output logic [3:0] r_ch0_inst_nr, r_ch1_inst_nr, r_ch2_inst_nr, r_ch3_inst_nr, r_ch4_inst_nr,
  output logic [3:0] r_ch5_inst_nr, r_ch6_inst_nr, r_ch7_inst_nr, r_ch8_inst_nr,
  output logic [3:0] r_ch0_vol, r_ch1_vol, r_ch2_vol, r_ch3_vol, r_ch4_vol,
  output logic [3:0] r_ch5_vol, r_ch6_vol, r_ch7_vol, r_ch8_vol,
  output logic       r_ch_rhy_en, r_ch_rhy_bd_on, r_ch_rhy_sd_on,
  output logic       r_ch_rhy_tom_on, r_ch_rhy_cym_on, r_ch_rhy_hh_on
);
  logic              we_d_reg;
  logic [7:0]        addr_lat_reg;
  logic [7:0]        ut_reg [NUM_UT];
  logic [5:0]        rhy_reg;
  logic [8:0]        fnum_reg  [NUM_CH];
  logic [2:0]        block_reg [NUM_CH];
  logic [3:0]        inst_reg  [NUM_CH];
  logic [3:0]        vol_reg   [NUM_CH];
  logic [NUM_CH-1:0] sust_reg, key_reg, key_evt_reg;

  logic              wr, accept, addr_wr, data_wr;
  logic [NUM_CH-1:0] lo_hit, ctrl_hit, iv_hit;
  logic [NUM_UT-1:0] ut_hit;
  logic [WAIT_W-1:0] load_val;

  assign wr = cpu_we & ~we_d_reg;
`ifdef YM2413_WR_BUSY_DROP_EN
  // Real silicon loses writes that arrive during the wait window.
  assign accept = wr & ~busy;
`else
  assign accept = wr;
`endif
  assign addr_wr  = accept & ~cpu_a0;
  assign data_wr  = accept & cpu_a0;
  assign load_val = cpu_a0 ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);

  ym2413_busy_timer #(.W(WAIT_W)) u_busy_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (load_val),
    .busy     (busy)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_dec
      assign lo_hit[gi]   = data_wr && ch_hit(addr_lat_reg, ADR_FNUM_LO, ch_idx_t'(gi));
      assign ctrl_hit[gi] = data_wr && ch_hit(addr_lat_reg, ADR_CTRL, ch_idx_t'(gi));
      assign iv_hit[gi]   = data_wr && ch_hit(addr_lat_reg, ADR_INST_VOL, ch_idx_t'(gi));
    end
    for (gi = 0; gi < NUM_UT; gi++) begin : g_ut_dec
      assign ut_hit[gi] = data_wr && (addr_lat_reg == (ADR_UT_BASE + 8'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      we_d_reg     <= 1'b0;
      addr_lat_reg <= '0;
      rhy_reg      <= '0;
      sust_reg     <= '0;
      key_reg      <= '0;
      key_evt_reg  <= '0;
      for (int i = 0; i < NUM_UT; i++) ut_reg[i] <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        fnum_reg[i]  <= '0;
        block_reg[i] <= '0;
        inst_reg[i]  <= '0;
        vol_reg[i]   <= '0;
      end
    end else begin
      we_d_reg <= cpu_we;
      if (addr_wr) addr_lat_reg <= cpu_d;
      if (data_wr && (addr_lat_reg == ADR_RHY)) rhy_reg <= cpu_d[5:0];
      for (int i = 0; i < NUM_UT; i++) begin
        if (ut_hit[i]) ut_reg[i] <= cpu_d;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        // Only a rising key_on produces an event; the pulse lasts one cycle.
        key_evt_reg[i] <= ctrl_hit[i] & cpu_d[4] & ~key_reg[i];
        if (lo_hit[i]) fnum_reg[i][7:0] <= cpu_d;
        if (ctrl_hit[i]) begin
          sust_reg[i]     <= cpu_d[5];
          key_reg[i]      <= cpu_d[4];
          block_reg[i]    <= cpu_d[3:1];
          fnum_reg[i][8]  <= cpu_d[0];
        end
        if (iv_hit[i]) begin
          inst_reg[i] <= cpu_d[7:4];
          vol_reg[i]  <= cpu_d[3:0];
        end
      end
    end
  end

  assign key_evt = key_evt_reg;

  assign r_ut_op0_am = ut_reg[0][7], r_ut_op0_vib = ut_reg[0][6], r_ut_op0_egtyp = ut_reg[0][5],
         r_ut_op0_ksr = ut_reg[0][4], r_ut_op0_mult = ut_reg[0][3:0];
  assign r_ut_op1_am = ut_reg[1][7], r_ut_op1_vib = ut_reg[1][6], r_ut_op1_egtyp = ut_reg[1][5],
         r_ut_op1_ksr = ut_reg[1][4], r_ut_op1_mult = ut_reg[1][3:0];
  assign r_ut_op0_ksl = ut_reg[2][7:6], r_ut_op0_tl = ut_reg[2][5:0];
  assign r_ut_op1_ksl = ut_reg[3][7:6], r_ut_op1_wf = ut_reg[3][4],
         r_ut_op0_wf = ut_reg[3][3], r_ut_op0_fb = ut_reg[3][2:0];
  assign r_ut_op0_ar = ut_reg[4][7:4], r_ut_op0_dr = ut_reg[4][3:0];
  assign r_ut_op1_ar = ut_reg[5][7:4], r_ut_op1_dr = ut_reg[5][3:0];
  assign r_ut_op0_sl = ut_reg[6][7:4], r_ut_op0_rr = ut_reg[6][3:0];
  assign r_ut_op1_sl = ut_reg[7][7:4], r_ut_op1_rr = ut_reg[7][3:0];

  assign r_ch_rhy_en = rhy_reg[5], r_ch_rhy_bd_on = rhy_reg[4], r_ch_rhy_sd_on = rhy_reg[3],
         r_ch_rhy_tom_on = rhy_reg[2], r_ch_rhy_cym_on = rhy_reg[1], r_ch_rhy_hh_on = rhy_reg[0];

  assign r_ch0_fnum = fnum_reg[0], r_ch0_block = block_reg[0], r_ch0_sust_on = sust_reg[0],
         r_ch0_key_on = key_reg[0], r_ch0_inst_nr = inst_reg[0], r_ch0_vol = vol_reg[0];
  assign r_ch1_fnum = fnum_reg[1], r_ch1_block = block_reg[1], r_ch1_sust_on = sust_reg[1],
         r_ch1_key_on = key_reg[1], r_ch1_inst_nr = inst_reg[1], r_ch1_vol = vol_reg[1];
  assign r_ch2_fnum = fnum_reg[2], r_ch2_block = block_reg[2], r_ch2_sust_on = sust_reg[2],
         r_ch2_key_on = key_reg[2], r_ch2_inst_nr = inst_reg[2], r_ch2_vol = vol_reg[2];
  assign r_ch3_fnum = fnum_reg[3], r_ch3_block = block_reg[3], r_ch3_sust_on = sust_reg[3],
         r_ch3_key_on = key_reg[3], r_ch3_inst_nr = inst_reg[3], r_ch3_vol = vol_reg[3];
  assign r_ch4_fnum = fnum_reg[4], r_ch4_block = block_reg[4], r_ch4_sust_on = sust_reg[4],
         r_ch4_key_on = key_reg[4], r_ch4_inst_nr = inst_reg[4], r_ch4_vol = vol_reg[4];
  assign r_ch5_fnum = fnum_reg[5], r_ch5_block = block_reg[5], r_ch5_sust_on = sust_reg[5],
         r_ch5_key_on = key_reg[5], r_ch5_inst_nr = inst_reg[5], r_ch5_vol = vol_reg[5];
  assign r_ch6_fnum = fnum_reg[6], r_ch6_block = block_reg[6], r_ch6_sust_on = sust_reg[6],
         r_ch6_key_on = key_reg[6], r_ch6_inst_nr = inst_reg[6], r_ch6_vol = vol_reg[6];
  assign r_ch7_fnum = fnum_reg[7], r_ch7_block = block_reg[7], r_ch7_sust_on = sust_reg[7],
         r_ch7_key_on = key_reg[7], r_ch7_inst_nr = inst_reg[7], r_ch7_vol = vol_reg[7];
  assign r_ch8_fnum = fnum_reg[8], r_ch8_block = block_reg[8], r_ch8_sust_on = sust_reg[8],
         r_ch8_key_on = key_reg[8], r_ch8_inst_nr = inst_reg[8], r_ch8_vol = vol_reg[8];
endmodule
